// File: rtl/uart_rx_pkg.sv
// Shared types and constant helpers for the UART receive control path:
// FSM state enum, baud-code to bit-time table and frame-length lookup.
package uart_rx_pkg;

    localparam int CNT_W_DEF = 19;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        DATA    = 2'd2,
        DONE_ST = 2'd3
    } rx_state_t;

    // Clock cycles per bit, rounded down; codes above 11 saturate at 921600 baud.
    function automatic int unsigned baud_k(input logic [3:0] code, input int unsigned clk_hz);
        int unsigned k;
        case (code)
            4'd0:    k = clk_hz / 32'd300;
            4'd1:    k = clk_hz / 32'd1200;
            4'd2:    k = clk_hz / 32'd2400;
            4'd3:    k = clk_hz / 32'd4800;
            4'd4:    k = clk_hz / 32'd9600;
            4'd5:    k = clk_hz / 32'd19200;
            4'd6:    k = clk_hz / 32'd38400;
            4'd7:    k = clk_hz / 32'd57600;
            4'd8:    k = clk_hz / 32'd115200;
            4'd9:    k = clk_hz / 32'd230400;
            4'd10:   k = clk_hz / 32'd460800;
            default: k = clk_hz / 32'd921600;
        endcase
        return k;
    endfunction

    // Bits per frame: start + 7/8 data + optional parity + stop.
    function automatic logic [3:0] frame_len(input logic eight, input logic pen);
        return 4'd9 + {3'b000, eight} + {3'b000, pen};
    endfunction

endpackage

// File: rtl/rx_engine_control_if.sv
// Bundle between the receive control FSM and its surroundings; the slave
// modport is the control block, the master side drives RX and the config.
interface rx_engine_control_if;
    import uart_rx_pkg::*;

    logic      RX;
    logic [3:0] BAUD;
    logic      EIGHT;
    logic      PEN;
    // start is a level; BTU and DONE are single-cycle strobes with no back-pressure.
    logic      start;
    logic      BTU;
    logic      DONE;
    logic      busy;
    rx_state_t state_dbg;

    modport master (
        output RX, BAUD, EIGHT, PEN,
        input  start, BTU, DONE, busy, state_dbg
    );

    modport slave (
        input  RX, BAUD, EIGHT, PEN,
        output start, BTU, DONE, busy, state_dbg
    );

endinterface

// File: rtl/rx_bit_timer.sv
// Bit-time generator: counts while enabled and strobes BTU at K/2 (half) or K,
// then restarts from zero. Held at zero while disabled.
module rx_bit_timer
    import uart_rx_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             half,
    input  logic [CNT_W-1:0] K,
    output logic             BTU
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] limit;

    always_comb begin
        limit = half ? (K >> 1) : K;
        BTU   = enable && (cnt_q == (limit - CNT_W'(1)));
        cnt_d = cnt_q + CNT_W'(1);
        if (!enable || BTU) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rx_engine_control.sv
// UART receive control FSM: start-bit validation, bit timing and frame count.
// Optional RX_SYNC_EN adds a two-flop synchronizer on RX (+2 cycles latency).
module rx_engine_control
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int          CNT_W  = CNT_W_DEF
) (
    input logic               clk,
    input logic               rst,
    rx_engine_control_if.slave bus
);

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic [3:0]       n_q, n_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic             rx;
    logic             btu;

`ifdef RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], bus.RX};
        end
    end

    assign rx = sync_q[1];
`else
    assign rx = bus.RX;
`endif

    rx_bit_timer #(
        .CNT_W(CNT_W)
    ) u_bit_timer (
        .clk   (clk),
        .rst   (rst),
        .enable(state_q != IDLE),
        .half  (state_q == START),
        .K     (k_q),
        .BTU   (btu)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        n_d       = n_q;
        bit_cnt_d = bit_cnt_q;
        if (btu) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
        end
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                // Frame format and baud are frozen here for the whole frame.
                if (!rx) begin
                    state_d = START;
                    k_d     = CNT_W'(baud_k(bus.BAUD, CLK_HZ));
                    n_d     = frame_len(bus.EIGHT, bus.PEN);
                end
            end
            START: begin
                if (btu) begin
                    if (rx) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (btu && (bit_cnt_d == n_q)) begin
                    state_d = DONE_ST;
                end
            end
            DONE_ST: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            n_q       <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            n_q       <= n_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // DONE trails the final BTU by one cycle so the stop bit is already shifted.
    assign bus.start     = (state_q == START);
    assign bus.BTU       = btu;
    assign bus.DONE      = (state_q == DONE_ST);
    assign bus.busy      = (state_q != IDLE);
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_rx_engine_control.sv
// Scoreboard bench for rx_engine_control: stimulus pushes expected BTU/DONE
// events (cycle + start flag) and a negedge monitor pops and compares them.
module tb_rx_engine_control;
    import uart_rx_pkg::*;

    localparam int unsigned CLK_HZ = 10_000_000;
    localparam int W = 34;
`ifdef RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int RATES [12] = '{300, 1200, 2400, 4800, 9600, 19200, 38400,
                                  57600, 115200, 230400, 460800, 921600};

    // Frames, LSB first: start bit in [0], stop/idle ones on top.
    localparam logic [10:0] F_8P = {1'b1, 1'b0, 8'h55, 1'b0};
    localparam logic [10:0] F_7  = {2'b11, 1'b1, 7'h2A, 1'b0};
    localparam logic [10:0] F_8  = {1'b1, 1'b1, 8'hA3, 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   last_done = -100;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] act_ev;
    logic [W-1:0] exp_ev;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rx_engine_control_if bus();

    rx_engine_control #(
        .CLK_HZ(CLK_HZ),
        .CNT_W (19)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- model helpers ----------------
    function automatic int tb_k(input int code);
        int c;
        c = (code > 11) ? 11 : code;
        return int'(CLK_HZ) / RATES[c];
    endfunction

    function automatic int tb_n(input logic eight, input logic pen);
        return 9 + int'(eight) + int'(pen);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle from which the FSM effectively sees an RX low driven now.
    function automatic int entry_cycle();
        int p0;
        p0 = cyc;
        if (SYNC_LAT == 0 && p0 == last_done) return p0 + 1;
        return p0 + SYNC_LAT;
    endfunction

    task automatic push_frame(input int eff, input int k, input int n, input int nbtu,
                              input bit with_done, output int done_cyc);
        int h;
        h = k / 2;
        for (int i = 0; i < nbtu; i++) begin
            exp_q.push_back({1'b0, (i == 0), 32'(eff + h + i * k)});
        end
        done_cyc = eff + h + (n - 1) * k + 1;
        if (with_done) exp_q.push_back({1'b1, 1'b0, 32'(done_cyc)});
    endtask

    task automatic drive_bits(input logic [10:0] bits, input int first, input int last, input int k);
        for (int i = first; i <= last; i++) begin
            bus.RX = bits[i];
            tick(k);
        end
    endtask

    // Sends a full frame and returns in the cycle DONE is expected.
    task automatic send_frame(input logic [10:0] bits, input int n, input int k);
        int eff;
        int done_cyc;
        eff = entry_cycle();
        push_frame(eff, k, n, n, 1'b1, done_cyc);
        drive_bits(bits, 0, n - 2, k);
        bus.RX = bits[n-1];
        tick(done_cyc - cyc);
        last_done = done_cyc;
        check("done_at_expected_cycle", 32'(bus.DONE), 32'd1);
    endtask

    task automatic check_quiet(input string name);
        check({name, "_start"}, 32'(bus.start), 32'd0);
        check({name, "_btu"},   32'(bus.BTU),   32'd0);
        check({name, "_done"},  32'(bus.DONE),  32'd0);
        check({name, "_busy"},  32'(bus.busy),  32'd0);
        check({name, "_state"}, 32'(bus.state_dbg), 32'(IDLE));
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (bus.BTU || bus.DONE) begin
            act_ev = {bus.DONE, bus.start, 32'(cyc)};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_event: done=%0b start=%0b cycle=%0d, none expected",
                         act_ev[33], act_ev[32], act_ev[31:0]);
            end else begin
                exp_ev = exp_q.pop_front();
                if (act_ev !== exp_ev) begin
                    n_errors++;
                    $display("FAIL event: got done=%0b start=%0b cycle=%0d, expected done=%0b start=%0b cycle=%0d",
                             act_ev[33], act_ev[32], act_ev[31:0],
                             exp_ev[33], exp_ev[32], exp_ev[31:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int eff;
        int dc;
        int k8;
        int k0;
        bus.RX    = 1'b1;
        bus.BAUD  = 4'd8;
        bus.EIGHT = 1'b1;
        bus.PEN   = 1'b1;
        k8 = tb_k(8);
        k0 = tb_k(0);

        rst = 1'b0;
        tick(3);
        check_quiet("reset");
        rst = 1'b1;
        tick(5);

        // 8 data + parity, code 8: 11 BTUs, DONE one cycle after the last.
        send_frame(F_8P, tb_n(1'b1, 1'b1), k8);
        check("t1_busy_in_done", 32'(bus.busy), 32'd1);
        tick(1);
        check("t1_busy_after_done", 32'(bus.busy), 32'd0);
        tick(20);

        // False start: RX low shorter than half a bit.
        eff = entry_cycle();
        push_frame(eff, k8, 11, 1, 1'b0, dc);
        bus.RX = 1'b0;
        tick(20);
        bus.RX = 1'b1;
        tick(k8 / 2 + 10);
        check_quiet("t2_after_false_start");
        tick(10);

        // 7 data, no parity; second frame driven low during the DONE cycle.
        bus.EIGHT = 1'b0;
        bus.PEN   = 1'b0;
        send_frame(F_7, tb_n(1'b0, 1'b0), k8);
        send_frame(F_7, tb_n(1'b0, 1'b0), k8);
        tick(10);

        // Top baud code saturates at 921600.
        bus.BAUD  = 4'd15;
        bus.EIGHT = 1'b1;
        bus.PEN   = 1'b0;
        send_frame(F_8, tb_n(1'b1, 1'b0), tb_k(15));
        tick(10);

        // Reset after the 5th BTU aborts the frame.
        bus.BAUD  = 4'd8;
        bus.PEN   = 1'b1;
        eff = entry_cycle();
        push_frame(eff, k8, 11, 5, 1'b0, dc);
        drive_bits(F_8P, 0, 4, k8);
        #2;
        rst = 1'b0;
        #1;
        check_quiet("t4_async_reset");
        tick(3);
        bus.RX = 1'b1;
        rst = 1'b1;
        tick(5);
        send_frame(F_8P, 11, k8);
        tick(10);

        // Config change after the 3rd BTU is ignored for the running frame.
        eff = entry_cycle();
        push_frame(eff, k8, 11, 11, 1'b1, dc);
        drive_bits(F_8P, 0, 2, k8);
        bus.BAUD  = 4'd0;
        bus.EIGHT = 1'b0;
        drive_bits(F_8P, 3, 9, k8);
        bus.RX = F_8P[10];
        tick(dc - cyc);
        last_done = dc;
        check("t5_done_unchanged_len", 32'(bus.DONE), 32'd1);
        tick(10);

        // Next frame picks up code 0: first BTU at K/2, then abort by reset.
        eff = entry_cycle();
        push_frame(eff, k0, tb_n(1'b0, 1'b1), 1, 1'b0, dc);
        bus.RX = 1'b0;
        tick(k0 / 2 + 10);
        check("t5_in_data_state", 32'(bus.state_dbg), 32'(DATA));
        #2;
        rst = 1'b0;
        #1;
        check_quiet("t5_abort");
        tick(2);
        bus.RX = 1'b1;
        rst = 1'b1;
        tick(20);

        check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rx_engine_control.md
Name: rx_engine_control

Overview:
- Control FSM and timing generator for the UART receive datapath.
- Detects the start bit, generates bit-time-up strobes (half-bit for the start bit, full-bit afterwards), and counts frame bits.
- Emits the start, BTU and DONE controls that drive datapath shifting and status-flag setting.
- Sits beside the receive datapath inside the full-UART receive engine; frame-format and baud selects come from the UART control register.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz; sets the bit-time constants
CNT_W, 19, bit-time counter width; must hold CLK_HZ/300

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
RX  input  1  serial receive line, idle high
BAUD  input  4  baud select code
EIGHT  input  1  1 = 8 data bits, 0 = 7
PEN  input  1  parity enable
start  output  1  high while the start bit is being validated
BTU  output  1  one-cycle bit-time-up strobe
DONE  output  1  one-cycle frame-complete strobe
busy  output  1  frame in progress (state != IDLE)

Behaviour:
- Reset: rst low asynchronously forces state IDLE and clears all counters and config latches. start=0, BTU=0, DONE=0, busy=0.
- Baud table, K = CLK_HZ/rate, rounded down:
  - Codes 0..11 select 300, 1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600.
  - Codes 12..15 select 921600.
- Config latch: BAUD, EIGHT and PEN are captured on the IDLE->START transition. Changes mid-frame are ignored until the next frame.
- Frame length N = 1 start + data + parity + stop. {EIGHT,PEN}: 00->9, 01->10, 10->10, 11->11.
- Bit timer:
  - Increments every cycle while state != IDLE.
  - BTU = (count == limit-1), where limit = K/2 in START and K in DATA.
  - On BTU the counter returns to 0. In IDLE the counter holds 0.
- Bit counter: increments on each BTU, cleared in IDLE.
- FSM states:
  - IDLE: on RX==0, go to START.
  - START (start=1): on BTU, if RX==0 go to DATA; if RX==1 (false start) go to IDLE with no DONE. The counters clear on that exit.
  - DATA (start=0): on the BTU where the bit counter reaches N, go to DONE_ST.
  - DONE_ST: DONE=1 for exactly one cycle, then IDLE. DONE is deliberately one cycle after the final BTU so the datapath has shifted the stop bit before its flags sample it.
- Latency:
  - The first BTU occurs K/2 cycles after entering START; each later BTU follows K cycles after the previous one.
  - Total BTUs per valid frame = N, and the datapath sees N-1 shifts (BTU & ~start).
- Boundary conditions:
  - RX low in the DONE_ST cycle is not detected; detection resumes in IDLE. The first valid start edge is therefore one cycle after DONE.
  - A BTU and a bit-count match occur in the same cycle; no simultaneous-event conflict is possible.
  - Reset mid-frame aborts the frame, and no DONE is ever issued for it.
  - RX glitches during DATA are not filtered and are sampled as-is.

Optional Feature:
- Macro: RX_SYNC_EN.
- Defined: RX passes through a two-flop synchronizer (reset value 1) before the FSM. All RX-relative timing shifts by +2 cycles.
- Undefined: RX is used directly and the source must be synchronous to clk.

Decomposition:
- Shared package uart_rx_pkg holds:
  - the state enum (IDLE, START, DATA, DONE_ST);
  - the baud-code-to-K constant function of CLK_HZ;
  - the frame-length function of {EIGHT,PEN};
  - the CNT_W default.
- One sub-module, rx_bit_timer, holds the counter, limit select (K vs K/2) and the BTU compare. Inputs: clk, rst, enable, half, K; output: BTU.

Test Plan:
1. BAUD=8 (K=868), EIGHT=1, PEN=1, frame 0x55 with parity and stop -> start high 434 cycles; BTUs at entry+434, then every 868; 11 BTUs total, 10 shifts; DONE exactly one cycle after the 11th BTU; busy low the cycle after DONE.
2. BAUD=8, RX low for 200 cycles then high -> BTU at entry+434 with start=1, FSM returns to IDLE; no DONE and zero shifts.
3. BAUD=8, EIGHT=0, PEN=0 -> 9 BTUs, DONE one cycle after the 9th; next frame started one cycle after DONE is detected.
4. Reset pulse after the 5th BTU -> start/BTU/DONE/busy 0 immediately (asynchronous); the following frame completes normally with the full BTU count.
5. BAUD switched 8->0 after the 3rd BTU -> BTU spacing stays 868 for the rest of the frame; the next frame uses K=333333.
6. RX_SYNC_EN defined, scenario 1 repeated -> every BTU and DONE delayed by exactly 2 cycles relative to the RX edge.
